// File: rtl/fp32_pkg.sv
// Shared definitions for the fp32 multiplier core: format constants,
// FSM state encoding and IEEE-754 field extractors.
package fp32_pkg;

    localparam int FP_BIAS = 127;
    localparam int FP_EXP_MAX = 255;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] fp_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp32_mul_core_if.sv
// Request/response bundle between the fpm controller and the multiplier.
interface fp32_mul_core_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/mant_mul_seq.sv
// 24x24 shift-add mantissa multiplier, one partial product per step.
module mant_mul_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [23:0] ma,
    input  logic [23:0] mb,
    output logic [47:0] product
);
    logic [47:0] ma_sh;
    logic [23:0] mb_r;
    logic [47:0] acc;

    // ma is shifted in place each step, so ma_sh always equals ma << step
    always_ff @(posedge clock) begin
        if (reset) begin
            ma_sh <= '0;
            mb_r  <= '0;
            acc   <= '0;
        end else if (load) begin
            ma_sh <= {24'h0, ma};
            mb_r  <= mb;
            acc   <= '0;
        end else if (step) begin
            if (mb_r[0]) acc <= acc + ma_sh;
            ma_sh <= ma_sh << 1;
            mb_r  <= mb_r >> 1;
        end
    end

    assign product = acc;
endmodule

// File: rtl/fp32_mul_core.sv
// Sequential IEEE-754 single-precision multiplier, truncating,
// flush-to-zero, one product per accepted start.
module fp32_mul_core #(
    parameter int MUL_STEPS = 24
) (
    input logic            clock,
    input logic            reset,
    fp32_mul_core_if.slave bus
);
    import fp32_pkg::*;

    localparam logic [4:0] LAST_STEP = 5'(MUL_STEPS - 1);

    state_t      state, state_nx;
    logic        sign_r;
    logic [7:0]  ea_r, eb_r;
    logic [4:0]  step_cnt;
    logic [31:0] result_r, result_nx;
    logic        result_en, load, step;
    logic [47:0] prod;

    mant_mul_seq u_mant (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .ma      ({1'b1, fp_frac(bus.op_a)}),
        .mb      ({1'b1, fp_frac(bus.op_b)}),
        .product (prod)
    );

    logic [7:0] a_exp, b_exp;
    logic       a_zero, a_inf, a_nan;
    logic       b_zero, b_inf, b_nan;
    logic       special, spec_sign;
    logic [31:0] spec_res;

    assign a_exp  = fp_exp(bus.op_a);
    assign b_exp  = fp_exp(bus.op_b);
    assign a_zero = (a_exp == 8'h00);
    assign b_zero = (b_exp == 8'h00);
    assign a_nan  = (a_exp == 8'(FP_EXP_MAX)) && (fp_frac(bus.op_a) != '0);
    assign b_nan  = (b_exp == 8'(FP_EXP_MAX)) && (fp_frac(bus.op_b) != '0);
    assign a_inf  = (a_exp == 8'(FP_EXP_MAX)) && (fp_frac(bus.op_a) == '0);
    assign b_inf  = (b_exp == 8'(FP_EXP_MAX)) && (fp_frac(bus.op_b) == '0);
    assign special   = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    assign spec_sign = fp_sign(bus.op_a) ^ fp_sign(bus.op_b);

    always_comb begin
        spec_res = {spec_sign, 31'h0};
        if (a_nan | b_nan)
            spec_res = FP_QNAN;
        else if ((a_inf & b_zero) | (a_zero & b_inf))
            spec_res = FP_QNAN;
        else if (a_inf | b_inf)
            spec_res = {spec_sign, 8'hFF, 23'h0};
    end

    // Exponent math in 10-bit signed so both overflow and underflow are visible
    logic signed [9:0] e_base, e_adj;
    logic [22:0] mant;
    logic [31:0] norm_res;
    logic        unused_low;

    assign e_base = $signed({2'b00, ea_r}) + $signed({2'b00, eb_r})
                  - $signed(10'(FP_BIAS));
    assign e_adj  = prod[47] ? e_base + 10'sd1 : e_base;
    assign mant   = prod[47] ? prod[46:24] : prod[45:23];
    assign unused_low = ^prod[22:0];

    always_comb begin
        norm_res = {sign_r, e_adj[7:0], mant};
        if (e_adj >= 10'sd255)
            norm_res = {sign_r, 8'hFF, 23'h0};
        else if (e_adj <= 10'sd0)
            norm_res = {sign_r, 31'h0};
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        step      = 1'b0;
        result_en = 1'b0;
        result_nx = norm_res;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load = 1'b1;
                    if (special) begin
                        state_nx  = DONE;
                        result_en = 1'b1;
                        result_nx = spec_res;
                    end else begin
                        state_nx = MUL;
                    end
                end
            end
            MUL: begin
                step = 1'b1;
                if (step_cnt == LAST_STEP) state_nx = NORM;
            end
            NORM: begin
                state_nx  = DONE;
                result_en = 1'b1;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            sign_r   <= 1'b0;
            ea_r     <= '0;
            eb_r     <= '0;
            step_cnt <= '0;
            result_r <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                sign_r   <= spec_sign;
                ea_r     <= a_exp;
                eb_r     <= b_exp;
                step_cnt <= '0;
            end else if (step) begin
                step_cnt <= step_cnt + 5'd1;
            end
            if (result_en) result_r <= result_nx;
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_r;
endmodule

// File: tb/tb_fp32_mul_core.sv
// Directed-vector bench for fp32_mul_core: products, latency,
// special cases, ignored start, mid-operation reset and back-to-back runs.
module tb_fp32_mul_core;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fp32_mul_core_if bus ();

    fp32_mul_core dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one request and follow it to done; returns observed latency
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit busy_ok);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clock);
            bus.start = 1'b0;
            lat++;
            if (!bus.busy) busy_ok = 1'b0;
        end while (!bus.done && lat < 40);
    endtask

    vec_t vecs[9];
    int lat;
    bit busy_ok;
    int dones;
    int t_done[4];
    int unstable;
    logic [31:0] prev;
    logic [31:0] b2b_a[4];
    logic [31:0] b2b_b[4];
    logic [31:0] b2b_r[4];

    initial begin
        vecs[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 26, "mul_1p5x2"};
        vecs[1] = '{32'h40400000, 32'h40400000, 32'h41100000, 26, "mul_3x3"};
        vecs[2] = '{32'hBF800000, 32'h40400000, 32'hC0400000, 26, "sign_neg"};
        vecs[3] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 26, "overflow"};
        vecs[4] = '{32'h00800000, 32'h00800000, 32'h00000000, 26, "underflow"};
        vecs[5] = '{32'h80000000, 32'h3F800000, 32'h80000000, 1, "neg_zero"};
        vecs[6] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1, "inf_x_zero"};
        vecs[7] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1, "nan_in"};
        vecs[8] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1, "neg_inf"};

        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_busy", {31'h0, bus.busy}, 32'h0);
        check("reset_done", {31'h0, bus.done}, 32'h0);
        check("reset_result", bus.result, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, lat, busy_ok);
            check({vecs[i].name, "_result"}, bus.result, vecs[i].exp);
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            check({vecs[i].name, "_busy"}, {31'h0, busy_ok}, 32'h1);
            @(negedge clock);
            check({vecs[i].name, "_idle"}, {30'h0, bus.busy, bus.done}, 32'h0);
            check({vecs[i].name, "_hold"}, bus.result, vecs[i].exp);
        end

        // Second start mid-operation must be ignored
        @(negedge clock);
        bus.start = 1'b1;
        bus.op_a  = 32'h3FC00000;
        bus.op_b  = 32'h40000000;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            bus.start = 1'b0;
            if (lat == 10) begin
                bus.start = 1'b1;
                bus.op_a  = 32'h40400000;
                bus.op_b  = 32'h40400000;
            end
        end while (!bus.done && lat < 40);
        check("ignored_start_latency", lat, 26);
        check("ignored_start_result", bus.result, 32'h40400000);
        @(negedge clock);
        check("ignored_start_idle", {31'h0, bus.busy}, 32'h0);

        // Reset mid-MUL discards the operation
        bus.start = 1'b1;
        bus.op_a  = 32'h40400000;
        bus.op_b  = 32'h40400000;
        lat = 0;
        do begin
            @(negedge clock);
            bus.start = 1'b0;
            lat++;
        end while (lat < 12);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_busy", {31'h0, bus.busy}, 32'h0);
        check("midreset_done", {31'h0, bus.done}, 32'h0);
        check("midreset_result", bus.result, 32'h0);
        dones = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.done) dones++;
        end
        check("midreset_no_done", dones, 0);

        // Back-to-back with start held high
        b2b_a = '{32'h3FC00000, 32'h40400000, 32'hBF800000, 32'h7F000000};
        b2b_b = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h40000000};
        b2b_r = '{32'h40400000, 32'h41100000, 32'hC0400000, 32'h7F800000};
        @(negedge clock);
        bus.start = 1'b1;
        bus.op_a  = b2b_a[0];
        bus.op_b  = b2b_b[0];
        prev = bus.result;
        for (int i = 0; i < 4; i++) begin
            lat = 0;
            unstable = 0;
            do begin
                @(negedge clock);
                lat++;
                if (!bus.done && bus.result !== prev) unstable++;
            end while (!bus.done && lat < 60);
            t_done[i] = cyc;
            check($sformatf("b2b%0d_result", i), bus.result, b2b_r[i]);
            if (i > 0)
                check($sformatf("b2b%0d_stable", i), unstable, 0);
            prev = bus.result;
            if (i < 3) begin
                bus.op_a = b2b_a[i+1];
                bus.op_b = b2b_b[i+1];
            end else begin
                bus.start = 1'b0;
            end
        end
        for (int i = 1; i < 4; i++)
            check($sformatf("b2b%0d_spacing", i), t_done[i] - t_done[i-1], 27);
        @(negedge clock);
        check("b2b_final_hold", bus.result, b2b_r[3]);
        check("b2b_final_idle", {31'h0, bus.busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp32_mul_core.md
# fp32_mul_core

Sequential IEEE-754 single-precision multiplier core that computes one product per start request. It sits directly upstream of the `fpm` result RAM: the `fpm` controller fetches two operands, pulses `start`, waits for `done`, and writes `result` into the 4-word result RAM that the judge port reads out. The mantissa product is built by a 24-step shift-add datapath; normalization, exponent handling, special cases and truncation are done in dedicated states.

## Interface
- Parameter `MUL_STEPS`, default 24: number of shift-add iterations, equal to the mantissa width including the hidden bit. Fixed; not meant to be overridden.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high. Returns the core to IDLE and clears all outputs.
- `start` in 1: request pulse. Sampled only in IDLE.
- `op_a` in 32: IEEE-754 operand A. Sampled on the accepting edge.
- `op_b` in 32: IEEE-754 operand B. Sampled on the accepting edge.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse in state DONE.
- `result` out 32: product. Valid from the `done` cycle and held until the next accepted `start` or `reset`.

## Operation
- States:
  - IDLE → MUL on `start`, normal operands.
  - IDLE → DONE on `start`, special operands.
  - MUL → MUL for `MUL_STEPS` cycles, then MUL → NORM.
  - NORM → DONE.
  - DONE → IDLE.
- Accept (IDLE with `start`=1):
  - Latch sign = a[31]^b[31], ea, eb.
  - Latch ma = {1,a[22:0]} and mb = {1,b[22:0]}.
  - Clear the 48-bit accumulator P and the step counter.
- MUL: each cycle, if mb[0] then P += ma << step. Then shift mb right and increment the step counter. Counter width is 5 bits; exit after step 23.
- NORM:
  - e = ea + eb − 127, computed as a 10-bit signed value.
  - If P[47]=1: mant = P[46:24], e = e + 1. Otherwise mant = P[45:23].
  - Rounding is truncation (toward zero).
  - If e ≥ 255: result = {sign, 8'hFF, 23'h0} (overflow to infinity).
  - If e ≤ 0: result = {sign, 31'h0} (underflow flushed to zero; no subnormal outputs).
  - Otherwise result = {sign, e[7:0], mant}.
- Special operands are decided at accept time and go directly to DONE. Classify each operand:
  - exponent = 0: zero. Subnormal inputs are flushed to zero.
  - exponent = 255 with nonzero fraction: NaN.
  - exponent = 255 with zero fraction: infinity.
- Special-case results, in this priority order:
  1. Any NaN input → 32'h7FC00000.
  2. Infinity × zero → 32'h7FC00000.
  3. Any infinity → {sign, 8'hFF, 23'h0}.
  4. Any zero → {sign, 31'h0}.
- `start` while busy: ignored, no effect, no queuing.
- `start` held high in the DONE cycle: ignored. It is accepted on the following cycle if still high, because the core is back in IDLE.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `result` = 32'h0, accumulator and counter = 0.
- Normal path, with `start` accepted at edge k:
  - MUL occupies cycles k+1 through k+24.
  - NORM is cycle k+25.
  - DONE is cycle k+26.
  - `done` = 1 and `result` is valid during cycle k+26. Latency is 26 cycles.
- Special path: DONE is cycle k+1, so `done` = 1 one cycle after acceptance.
- `busy` rises in cycle k+1 and falls after the DONE cycle.
- `result` updates exactly when entering DONE and is otherwise stable.
- Back-to-back operation: the next `start` can be accepted in the cycle after DONE, giving a minimum of 27 cycles per normal operation.
- `reset` asserted in any state, including mid-MUL: on the next edge the core is in IDLE with every output at its reset value. The partial product is discarded and no `done` is issued.

## Structure
- Shared package `fp32_pkg` holds:
  - `FP_BIAS` = 127 and `FP_EXP_MAX` = 255.
  - `FP_QNAN` = 32'h7FC00000.
  - State encoding IDLE/MUL/NORM/DONE (2 bits).
  - Field-extract helpers for sign, exponent and fraction.
- Sub-module `mant_mul_seq`: 24×24 shift-add multiplier.
  - Ports: `clock`, `reset`, `load`, `step`, `ma`, `mb`, `product[47:0]`.
  - Driven by the core FSM.
- The exponent, normalization and special-case logic stays in `fp32_mul_core`.

## Test plan
- 3FC00000 × 40000000 (1.5 × 2.0) → `result` 40400000. `done` arrives exactly 26 cycles after `start` is accepted, and `busy` is high throughout.
- 40400000 × 40400000 (3 × 3) → 41100000, exercising the P[47] normalization path. BF800000 × 40400000 → C0400000, checking the sign.
- 7F000000 × 40000000 → 7F800000 (overflow). 00800000 × 00800000 → 00000000 (underflow flush). 80000000 × 3F800000 → 80000000 (signed zero, special path with `done` 1 cycle after acceptance).
- 7F800000 × 00000000 → 7FC00000. 7FC00001 × 3F800000 → 7FC00000. FF800000 × 40000000 → FF800000.
- `start` pulsed again at cycle k+10 of an operation → ignored; first result unchanged. Assert `reset` at cycle k+12 → next cycle: `busy` = 0, `done` = 0, `result` = 0, and no `done` pulse follows.
- Four back-to-back operations with `start` held high → each `done` is spaced 27 cycles apart, and each `result` is held stable between its `done` and the next acceptance.
